seg7_mux_driver: RTL and testbench

- Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits that share one segment bus.
- Hex-decodes one nibble per digit slot, scans the anodes at a divided refresh rate, and inserts a ghost-blanking gap at the start of each slot.
- Value updates are double-buffered so that a new value only becomes visible at a frame boundary, which prevents torn displays.
- Sits between the CPU debug/register-display path and the board's 7-segment pins.

---
 rtl/seg7_mux_driver_pkg.sv | 27 ++
 rtl/seg7_mux_driver_if.sv | 27 ++
 rtl/seg7_mux_driver_hex_decode.sv | 14 +
 rtl/seg7_mux_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_mux_driver.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_mux_driver_pkg.sv
// Shared types and constants for the multiplexed 7-segment driver.
// Segment vectors are ordered a..g with seg[0] = a, active-low.
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  // Active-low hex glyphs, indexed by nibble value.
  localparam seg_t HEX_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Bits needed to hold 0..n-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_mux_driver_if.sv
// Display bus between the register-display path (master) and the
// 7-segment driver (slave): load strobe with its payload, plus the pins.
interface seg7_mux_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  seg_t                    seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output value, dp_in, digit_en, load,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  value, dp_in, digit_en, load,
    output seg, dp, an, frame_tick
  );

endinterface

// File: rtl/seg7_mux_driver_hex_decode.sv
// Combinational nibble to active-low segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg_o = HEX_TABLE[nibble_i];
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-slot ghost
// blanking and frame-aligned double buffering of the displayed value.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN suppresses leading
// zero digits (digit 0 always shown) when a new value is committed.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_mux_driver_if.slave bus
);

  localparam int unsigned      CNT_W     = clog2(SLOT_CYCLES);
  localparam int unsigned      IDX_W     = clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrapped_q;
  logic                    slot_end, frame_end;

  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;

  logic [3:0]              nibble;
  seg_t                    nibble_seg;

  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q;

  // Slot counter and digit index sequencing.
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Pending capture on load; commit to active at the frame wrap.
  // The commit reads the already-updated pending value, which gives the
  // same-cycle bypass for a load landing exactly on the wrap.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_in;
      pend_en_d  = bus.digit_en;
    end
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_en_d  = act_en_q;
    if (frame_end) begin
      act_val_d = pend_val_d;
      act_dp_d  = pend_dp_d;
      act_en_d  = pend_en_d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
        if ((pend_val_d >> (4*k)) == '0) act_en_d[k] = 1'b0;
      end
`endif
    end
  end

  // Scan position and display buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      wrapped_q  <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wrapped_q  <= frame_end;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
    end
  end

  // Select the active nibble of the digit being scanned.
  always_comb begin
    nibble = act_val_q[4*idx_q +: 4];
  end

  seg7_hex_decode u_dec (
    .nibble_i (nibble),
    .seg_o    (nibble_seg)
  );

  // Pin values for the current scan position: dark gap, then the digit.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (cnt_q >= BLANK_END) begin
      an_d[idx_q] = 1'b0;
      if (act_en_q[idx_q]) begin
        seg_d = nibble_seg;
        dp_d  = ~act_dp_q[idx_q];
      end
    end
  end

  // Output registers; frame_tick follows the wrap by one cycle so it
  // lines up with the first digit-0 pin values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= wrapped_q;
    end
  end

  // Drive the bus pins from the registers.
  always_comb begin
    bus.seg        = seg_q;
    bus.dp         = dp_q;
    bus.an         = an_q;
    bus.frame_tick = tick_q;
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: cycle-indexed behavioural model compared
// every cycle, plus hand-computed pin values for the directed scenarios.
module tb_seg7_mux_driver;

  localparam int ND    = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * SLOT;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cur_j = 0;

  always #5 clk = ~clk;

  seg7_mux_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_mux_driver #(
    .NUM_DIGITS   (ND),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: m_n counts clock edges since reset release; slot position and
  // digit follow arithmetically from it.
  int         m_n = 0;
  logic [15:0] m_pv = '0, m_av = '0;
  logic [3:0]  m_pd = '0, m_ad = '0, m_pe = '0, m_ae = '0;
  logic [6:0]  e_seg = 7'b1111111;
  logic        e_dp = 1'b1;
  logic [3:0]  e_an = 4'b1111;
  logic        e_tick = 1'b0;

  function automatic logic [3:0] eff_en(input logic [15:0] v, input logic [3:0] e);
    logic [3:0] r;
    r = e;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int k = 1; k < ND; k++) begin
      if (int'(v) < (1 << (4*k))) r[k] = 1'b0;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int c;
    int k;
    if (!rst_n) begin
      m_n = 0;
      m_pv = '0; m_pd = '0; m_pe = '0;
      m_av = '0; m_ad = '0; m_ae = '0;
      e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111; e_tick = 1'b0;
    end else begin
      c = m_n % SLOT;
      k = (m_n / SLOT) % ND;
      e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111;
      if (c >= BLANK) begin
        e_an = ~(4'b0001 << k);
        if (m_ae[k]) begin
          e_seg = pat[m_av[4*k +: 4]];
          e_dp  = ~m_ad[k];
        end
      end
      e_tick = (m_n > 0) && (m_n % FRAME == 0);
      if (bus.load) begin
        m_pv = bus.value; m_pd = bus.dp_in; m_pe = bus.digit_en;
      end
      if (m_n % FRAME == FRAME - 1) begin
        m_av = m_pv; m_ad = m_pd; m_ae = eff_en(m_pv, m_pe);
      end
      m_n++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("seg", 32'(bus.seg), 32'(e_seg));
      chk("dp", 32'(bus.dp), 32'(e_dp));
      chk("an", 32'(bus.an), 32'(e_an));
      chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    bus.value = v; bus.dp_in = d; bus.digit_en = e; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2*FRAME + 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_tick) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_tick: no frame_tick within %0d cycles, expected one", 2*FRAME + 4);
    end
    cur_j = 0;
  endtask

  task automatic at_lit(input string name, input int j, input logic [3:0] an,
                        input logic [6:0] seg, input logic dp);
    repeat (j - cur_j) @(negedge clk);
    cur_j = j;
    chk({name, "_an"}, 32'(bus.an), 32'(an));
    chk({name, "_seg"}, 32'(bus.seg), 32'(seg));
    chk({name, "_dp"}, 32'(bus.dp), 32'(dp));
  endtask

  initial begin
    bus.value = '0; bus.dp_in = '0; bus.digit_en = '0; bus.load = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk_en = 1'b1;

    // Reset hold and release.
    repeat (5) @(negedge clk);
    chk("rst_seg", 32'(bus.seg), 32'h7f);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_an", 32'(bus.an), 32'hf);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("first_lit_an", 32'(bus.an), 32'he);
    chk("first_lit_seg", 32'(bus.seg), 32'h7f);

    // Basic scan of 0x12AF.
    @(posedge clk); #1;
    do_load(16'h12AF, 4'b0100, 4'b1111);
    wait_tick();
    at_lit("scan_gap0", 0, 4'b1111, 7'b1111111, 1'b1);
    at_lit("scan_gap1", 1, 4'b1111, 7'b1111111, 1'b1);
    at_lit("scan_d0", 2, 4'b1110, 7'b0111000, 1'b1);
    at_lit("scan_d0_end", 7, 4'b1110, 7'b0111000, 1'b1);
    at_lit("scan_d1_gap", 8, 4'b1111, 7'b1111111, 1'b1);
    at_lit("scan_d1", 10, 4'b1101, 7'b0001000, 1'b1);
    at_lit("scan_d2", 18, 4'b1011, 7'b0010010, 1'b0);
    at_lit("scan_d3", 26, 4'b0111, 7'b1001111, 1'b1);
    repeat (31 - cur_j) @(negedge clk);
    chk("tick_before_period", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    chk("tick_period", 32'(bus.frame_tick), 32'h1);

    // Two loads within a frame: last one wins, only at the next frame.
    repeat (10) @(posedge clk); #1;
    do_load(16'h1111, 4'b0000, 4'b1111);
    @(posedge clk); #1;
    do_load(16'h2222, 4'b0000, 4'b1111);
    wait_tick();
    at_lit("dbuf_d0", 2, 4'b1110, 7'b0010010, 1'b1);
    at_lit("dbuf_d3", 26, 4'b0111, 7'b0010010, 1'b1);

    // Load landing on the wrap edge shows in the very next frame.
    wait_tick();
    repeat (30) @(posedge clk); #1;
    do_load(16'h0005, 4'b0000, 4'b1111);
    wait_tick();
    at_lit("bypass_d0", 2, 4'b1110, 7'b0100100, 1'b1);

    // digit_en gating keeps the anode but darkens the segments.
    do_load(16'h8888, 4'b1111, 4'b0101);
    wait_tick();
    at_lit("en_d0", 2, 4'b1110, 7'b0000000, 1'b0);
    at_lit("en_d1", 10, 4'b1101, 7'b1111111, 1'b1);
    at_lit("en_d2", 18, 4'b1011, 7'b0000000, 1'b0);
    at_lit("en_d3", 26, 4'b0111, 7'b1111111, 1'b1);

    // Leading zeros.
    do_load(16'h0030, 4'b0000, 4'b1111);
    wait_tick();
    at_lit("lz_d0", 2, 4'b1110, 7'b0000001, 1'b1);
    at_lit("lz_d1", 10, 4'b1101, 7'b0000110, 1'b1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    at_lit("lz_d2", 18, 4'b1011, 7'b1111111, 1'b1);
    at_lit("lz_d3", 26, 4'b0111, 7'b1111111, 1'b1);
`else
    at_lit("lz_d2", 18, 4'b1011, 7'b0000001, 1'b1);
    at_lit("lz_d3", 26, 4'b0111, 7'b0000001, 1'b1);
`endif

    // Asynchronous reset mid-scan.
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_an", 32'(bus.an), 32'hf);
    chk("midrst_seg", 32'(bus.seg), 32'h7f);
    chk("midrst_dp", 32'(bus.dp), 32'h1);
    chk("midrst_tick", 32'(bus.frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized loads against the model.
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 9) == 0) begin
        bus.value    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        bus.dp_in    = 4'($urandom);
        bus.digit_en = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
        bus.load     = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (FRAME + 2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
